mem_access_unit: RTL and testbench

//  Registered memory-access (MA) stage of the 32-bit pipelined RISC core; successor to the combinational ld/st path.

---
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory port of the MA stage: req/ack handshake, word address,
// byte enables, write data and returned read data.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    // The MA stage issues requests and receives completion.
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    // The data memory answers requests.
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Registered memory-access stage of the 32-bit RISC pipeline.
// Accepts one EX result per transaction, issues byte/half/word loads and
// stores on a req/ack data-memory port, detects misalignment and bus
// timeouts, and registers the outcome into the MA/WB boundary. EX is
// stalled through in_ready while a memory access is outstanding.
// ADDR_W is expected in the range 3..32.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_alu_result,
    input  logic [31:0]            in_op2,
    input  logic                   in_is_ld,
    input  logic                   in_is_st,
    input  logic [1:0]             in_size,
    input  logic                   in_unsigned,
    input  logic [RD_W-1:0]        in_rd,
    input  logic                   in_wb_en,
    mem_access_unit_if.master      mem,
    output logic                   wb_valid,
    output logic [31:0]            wb_result,
    output logic [RD_W-1:0]        wb_rd,
    output logic                   wb_en,
    output logic                   wb_misalign,
    output logic                   wb_bus_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // Byte enables for a store of the given size at byte offset off.
    function automatic logic [3:0] laneEnable(input logic [1:0] size,
                                              input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane it could land in, so the
    // byte enables alone select the written bytes.
    function automatic logic [31:0] laneData(input logic [1:0]  size,
                                             input logic [31:0] op2);
        logic [31:0] data;
        case (size)
            SZ_BYTE: data = {4{op2[7:0]}};
            SZ_HALF: data = {2{op2[15:0]}};
            default: data = op2;
        endcase
        return data;
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] loadExtract(input logic [31:0] rdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        uns);
        logic [31:0]        shifted;
        logic signed [7:0]  byteVal;
        logic signed [15:0] halfVal;
        logic [31:0]        result;
        shifted = rdata >> {off, 3'b000};
        byteVal = shifted[7:0];
        halfVal = shifted[15:0];
        case (size)
            SZ_BYTE: result = uns ? {24'b0, byteVal} : {{24{byteVal[7]}}, byteVal};
            SZ_HALF: result = uns ? {16'b0, halfVal} : {{16{halfVal[15]}}, halfVal};
            default: result = rdata;
        endcase
        return result;
    endfunction

    // Control state
    state_t            state, stateN;
    logic [CNT_W-1:0]  cnt, cntN;

    // Request stage: memory port registers
    logic              memReq_p0, memReqN;
    logic              memWe_p0, memWeN;
    logic [ADDR_W-1:0] memAddr_p0, memAddrN;
    logic [3:0]        memBe_p0, memBeN;
    logic [31:0]       memWdata_p0, memWdataN;

    // Request stage: transaction context held while BUSY
    logic              isLd_p0, isLdN;
    logic [1:0]        size_p0, sizeN;
    logic [1:0]        off_p0, offN;
    logic              uns_p0, unsN;
    logic [RD_W-1:0]   rd_p0, rdN;
    logic              wbEnHold_p0, wbEnHoldN;
    logic [31:0]       ea_p0, eaN;

    // Writeback stage: MA/WB boundary registers
    logic              vld_p1, vldN;
    logic [31:0]       wbResult_p1, wbResultN;
    logic [RD_W-1:0]   wbRd_p1, wbRdN;
    logic              wbEn_p1, wbEnN;
    logic              misalign_p1, misalignN;
    logic              busErr_p1, busErrN;

    logic              isMem;
    logic              misaligned;

    assign in_ready = (state == IDLE);

    assign mem.mem_req   = memReq_p0;
    assign mem.mem_we    = memWe_p0;
    assign mem.mem_addr  = memAddr_p0;
    assign mem.mem_be    = memBe_p0;
    assign mem.mem_wdata = memWdata_p0;

    assign wb_valid    = vld_p1;
    assign wb_result   = wbResult_p1;
    assign wb_rd       = wbRd_p1;
    assign wb_en       = wbEn_p1;
    assign wb_misalign = misalign_p1;
    assign wb_bus_err  = busErr_p1;

    // Classify the incoming transaction: memory op and alignment.
    always_comb begin
        isMem      = in_is_ld | in_is_st;
        misaligned = (in_size == 2'b11)
                   | ((in_size == SZ_HALF) & in_alu_result[0])
                   | ((in_size == SZ_WORD) & (in_alu_result[1:0] != 2'b00));
    end

    // Next-state and next-register logic for the IDLE/BUSY controller.
    always_comb begin
        stateN      = state;
        cntN        = cnt;
        memReqN     = memReq_p0;
        memWeN      = memWe_p0;
        memAddrN    = memAddr_p0;
        memBeN      = memBe_p0;
        memWdataN   = memWdata_p0;
        isLdN       = isLd_p0;
        sizeN       = size_p0;
        offN        = off_p0;
        unsN        = uns_p0;
        rdN         = rd_p0;
        wbEnHoldN   = wbEnHold_p0;
        eaN         = ea_p0;
        vldN        = 1'b0;
        wbResultN   = wbResult_p1;
        wbRdN       = wbRd_p1;
        wbEnN       = 1'b0;
        misalignN   = 1'b0;
        busErrN     = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!isMem) begin
                        vldN      = 1'b1;
                        wbResultN = in_alu_result;
                        wbRdN     = in_rd;
                        wbEnN     = in_wb_en;
                    end else if (misaligned) begin
                        vldN      = 1'b1;
                        wbResultN = in_alu_result;
                        wbRdN     = in_rd;
                        misalignN = 1'b1;
                    end else begin
                        stateN    = BUSY;
                        cntN      = '0;
                        memReqN   = 1'b1;
                        memWeN    = ~in_is_ld;
                        memAddrN  = {in_alu_result[ADDR_W-1:2], 2'b00};
                        memBeN    = in_is_ld ? 4'b0000 : laneEnable(in_size, in_alu_result[1:0]);
                        memWdataN = in_is_ld ? 32'b0 : laneData(in_size, in_op2);
                        isLdN     = in_is_ld;
                        sizeN     = in_size;
                        offN      = in_alu_result[1:0];
                        unsN      = in_unsigned;
                        rdN       = in_rd;
                        wbEnHoldN = in_wb_en;
                        eaN       = in_alu_result;
                    end
                end
            end
            BUSY: begin
                cntN = cnt + 1'b1;
                if (mem.mem_ack) begin
                    stateN    = IDLE;
                    memReqN   = 1'b0;
                    memWeN    = 1'b0;
                    memBeN    = 4'b0000;
                    vldN      = 1'b1;
                    wbRdN     = rd_p0;
                    wbEnN     = isLd_p0 & wbEnHold_p0;
                    wbResultN = isLd_p0 ? loadExtract(mem.mem_rdata, size_p0, off_p0, uns_p0)
                                        : ea_p0;
                end else if (cnt == CNT_LAST) begin
                    stateN    = IDLE;
                    memReqN   = 1'b0;
                    memWeN    = 1'b0;
                    memBeN    = 4'b0000;
                    vldN      = 1'b1;
                    wbRdN     = rd_p0;
                    wbResultN = ea_p0;
                    busErrN   = 1'b1;
                end
            end
            default: stateN = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateN;
    end

    // Memory port and MA/WB boundary registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            memReq_p0   <= 1'b0;
            memWe_p0    <= 1'b0;
            memAddr_p0  <= '0;
            memBe_p0    <= 4'b0000;
            memWdata_p0 <= 32'b0;
            vld_p1      <= 1'b0;
            wbResult_p1 <= 32'b0;
            wbRd_p1     <= '0;
            wbEn_p1     <= 1'b0;
            misalign_p1 <= 1'b0;
            busErr_p1   <= 1'b0;
        end else begin
            cnt         <= cntN;
            memReq_p0   <= memReqN;
            memWe_p0    <= memWeN;
            memAddr_p0  <= memAddrN;
            memBe_p0    <= memBeN;
            memWdata_p0 <= memWdataN;
            vld_p1      <= vldN;
            wbResult_p1 <= wbResultN;
            wbRd_p1     <= wbRdN;
            wbEn_p1     <= wbEnN;
            misalign_p1 <= misalignN;
            busErr_p1   <= busErrN;
        end
    end

    // Transaction context; only meaningful while BUSY, so never reset.
    always_ff @(posedge clk) begin
        isLd_p0     <= isLdN;
        size_p0     <= sizeN;
        off_p0      <= offN;
        uns_p0      <= unsN;
        rd_p0       <= rdN;
        wbEnHold_p0 <= wbEnHoldN;
        ea_p0       <= eaN;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table-driven pass-through/misalign
// and load/store vectors, plus timeout, late-ack and reset sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_op2;
    logic        in_is_ld;
    logic        in_is_st;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [4:0]  in_rd;
    logic        in_wb_en;
    logic        wb_valid;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd;
    logic        wb_en;
    logic        wb_misalign;
    logic        wb_bus_err;

    int errors = 0;
    int checks = 0;

    mem_access_unit_if #(.ADDR_W(32)) memBus ();

    mem_access_unit #(.ADDR_W(32), .RD_W(5), .TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_alu_result (in_alu_result),
        .in_op2        (in_op2),
        .in_is_ld      (in_is_ld),
        .in_is_st      (in_is_st),
        .in_size       (in_size),
        .in_unsigned   (in_unsigned),
        .in_rd         (in_rd),
        .in_wb_en      (in_wb_en),
        .mem           (memBus),
        .wb_valid      (wb_valid),
        .wb_result     (wb_result),
        .wb_rd         (wb_rd),
        .wb_en         (wb_en),
        .wb_misalign   (wb_misalign),
        .wb_bus_err    (wb_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        isLd;
        logic        isSt;
        logic [1:0]  size;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        wbEn;
        logic [31:0] expResult;
        logic        expEn;
        logic        expMis;
    } passVec_t;

    typedef struct {
        logic        isLd;
        logic        isSt;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] ea;
        logic [31:0] op2;
        logic [31:0] rdata;
        int          waitCyc;
        logic        wbEn;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic        expWe;
        logic [31:0] expWdata;
        logic [31:0] expResult;
        logic        chkResult;
        logic        expEn;
    } memVec_t;

    passVec_t passTab[7];
    memVec_t  memTab[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] alu, input logic [31:0] op2,
                         input logic [4:0] rd, input logic en);
        in_valid      = 1'b1;
        in_is_ld      = ld;
        in_is_st      = st;
        in_size       = sz;
        in_unsigned   = uns;
        in_alu_result = alu;
        in_op2        = op2;
        in_rd         = rd;
        in_wb_en      = en;
    endtask

    initial begin
        int reqCycles;
        in_valid = 0; in_is_ld = 0; in_is_st = 0; in_size = 0; in_unsigned = 0;
        in_alu_result = 0; in_op2 = 0; in_rd = 0; in_wb_en = 0;
        memBus.mem_ack = 0; memBus.mem_rdata = 0;

        //              ld st size alu           rd  en  expResult     expEn expMis
        passTab[0] = '{0, 0, 2'b10, 32'h0000_1234, 5, 1, 32'h0000_1234, 1, 0};
        passTab[1] = '{0, 0, 2'b11, 32'hFFFF_FFFF, 31, 0, 32'hFFFF_FFFF, 0, 0};
        passTab[2] = '{1, 0, 2'b10, 32'h0000_0102, 7, 1, 32'h0000_0102, 0, 1};
        passTab[3] = '{1, 0, 2'b01, 32'h0000_0101, 8, 1, 32'h0000_0101, 0, 1};
        passTab[4] = '{0, 1, 2'b10, 32'h0000_0103, 9, 0, 32'h0000_0103, 0, 1};
        passTab[5] = '{1, 0, 2'b11, 32'h0000_0100, 10, 1, 32'h0000_0100, 0, 1};
        passTab[6] = '{0, 1, 2'b01, 32'h0000_0103, 11, 1, 32'h0000_0103, 0, 1};

        //             ld st size  uns ea             op2            rdata          wait en addr           be       we wdata          result        chk expEn
        memTab[0] = '{1, 0, 2'b00, 0, 32'h0000_0103, 32'h0,         32'h80FF_FF00, 1, 1, 32'h0000_0100, 4'b0000, 0, 32'h0,         32'hFFFF_FF80, 1, 1};
        memTab[1] = '{1, 0, 2'b01, 1, 32'h0000_0102, 32'h0,         32'hBEEF_0000, 0, 1, 32'h0000_0100, 4'b0000, 0, 32'h0,         32'h0000_BEEF, 1, 1};
        memTab[2] = '{0, 1, 2'b00, 0, 32'h0000_0101, 32'h0000_00AA, 32'h0,         0, 1, 32'h0000_0100, 4'b0010, 1, 32'hAAAA_AAAA, 32'h0,         0, 0};
        memTab[3] = '{1, 0, 2'b01, 0, 32'h0000_0106, 32'h0,         32'h8001_0000, 2, 1, 32'h0000_0104, 4'b0000, 0, 32'h0,         32'hFFFF_8001, 1, 1};
        memTab[4] = '{1, 0, 2'b00, 1, 32'h0000_0100, 32'h0,         32'h1234_56F0, 0, 1, 32'h0000_0100, 4'b0000, 0, 32'h0,         32'h0000_00F0, 1, 1};
        memTab[5] = '{1, 0, 2'b10, 0, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 3, 1, 32'h0000_0104, 4'b0000, 0, 32'h0,         32'hDEAD_BEEF, 1, 1};
        memTab[6] = '{0, 1, 2'b01, 0, 32'h0000_010A, 32'h1234_CAFE, 32'h0,         0, 1, 32'h0000_0108, 4'b1100, 1, 32'hCAFE_CAFE, 32'h0,         0, 0};
        memTab[7] = '{0, 1, 2'b10, 0, 32'h0000_010C, 32'h0123_4567, 32'h0,         1, 0, 32'h0000_010C, 4'b1111, 1, 32'h0123_4567, 32'h0,         0, 0};
        memTab[8] = '{1, 1, 2'b00, 1, 32'h0000_0101, 32'hFFFF_FFFF, 32'h0000_5A00, 0, 1, 32'h0000_0100, 4'b0000, 0, 32'h0,         32'h0000_005A, 1, 1};
        memTab[9] = '{1, 0, 2'b00, 0, 32'h0000_0102, 32'h0,         32'h007F_0000, 0, 0, 32'h0000_0100, 4'b0000, 0, 32'h0,         32'h0000_007F, 1, 0};

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst in_ready", in_ready, 1);
        check("rst mem_req", memBus.mem_req, 0);
        check("rst mem_addr", memBus.mem_addr, 0);
        check("rst mem_be", memBus.mem_be, 0);
        check("rst wb_valid", wb_valid, 0);
        check("rst wb_result", wb_result, 0);
        check("rst wb_flags", {wb_en, wb_misalign, wb_bus_err}, 0);
        reset = 1'b0;
        tick();

        // Pass-through and misaligned ops, back to back
        for (int i = 0; i < 7; i++) begin
            drive(passTab[i].isLd, passTab[i].isSt, passTab[i].size, 1'b0,
                  passTab[i].alu, 32'h0, passTab[i].rd, passTab[i].wbEn);
            check($sformatf("pass%0d in_ready", i), in_ready, 1);
            tick();
            check($sformatf("pass%0d wb_valid", i), wb_valid, 1);
            check($sformatf("pass%0d wb_result", i), wb_result, passTab[i].expResult);
            check($sformatf("pass%0d wb_rd", i), wb_rd, passTab[i].rd);
            check($sformatf("pass%0d wb_en", i), wb_en, passTab[i].expEn);
            check($sformatf("pass%0d wb_misalign", i), wb_misalign, passTab[i].expMis);
            check($sformatf("pass%0d mem_req", i), memBus.mem_req, 0);
        end
        in_valid = 1'b0;
        tick();
        check("pass wb_valid pulse", wb_valid, 0);
        check("pass wb_misalign pulse", wb_misalign, 0);

        // Aligned loads and stores
        for (int i = 0; i < 10; i++) begin
            drive(memTab[i].isLd, memTab[i].isSt, memTab[i].size, memTab[i].uns,
                  memTab[i].ea, memTab[i].op2, 5'(i + 1), memTab[i].wbEn);
            tick();
            in_valid = 1'b0;
            check($sformatf("mem%0d mem_req", i), memBus.mem_req, 1);
            check($sformatf("mem%0d mem_addr", i), memBus.mem_addr, memTab[i].expAddr);
            check($sformatf("mem%0d mem_be", i), memBus.mem_be, memTab[i].expBe);
            check($sformatf("mem%0d mem_we", i), memBus.mem_we, memTab[i].expWe);
            check($sformatf("mem%0d mem_wdata", i), memBus.mem_wdata, memTab[i].expWdata);
            check($sformatf("mem%0d in_ready busy", i), in_ready, 0);
            for (int w = 0; w < memTab[i].waitCyc; w++) begin
                tick();
                check($sformatf("mem%0d req held", i), memBus.mem_req, 1);
                check($sformatf("mem%0d wb idle", i), wb_valid, 0);
            end
            memBus.mem_rdata = memTab[i].rdata;
            memBus.mem_ack   = 1'b1;
            tick();
            memBus.mem_ack   = 1'b0;
            memBus.mem_rdata = 32'hA5A5_A5A5;
            check($sformatf("mem%0d wb_valid", i), wb_valid, 1);
            check($sformatf("mem%0d mem_req done", i), memBus.mem_req, 0);
            check($sformatf("mem%0d in_ready", i), in_ready, 1);
            check($sformatf("mem%0d wb_en", i), wb_en, memTab[i].expEn);
            check($sformatf("mem%0d wb_rd", i), wb_rd, 32'(i + 1));
            check($sformatf("mem%0d wb_bus_err", i), wb_bus_err, 0);
            if (memTab[i].chkResult)
                check($sformatf("mem%0d wb_result", i), wb_result, memTab[i].expResult);
            tick();
            check($sformatf("mem%0d wb_valid pulse", i), wb_valid, 0);
        end

        // Timeout: store with no ack
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h1122_3344, 5'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        reqCycles = 0;
        while (memBus.mem_req && reqCycles < 40) begin
            reqCycles++;
            tick();
        end
        check("timeout req cycles", reqCycles, 16);
        check("timeout wb_valid", wb_valid, 1);
        check("timeout wb_bus_err", wb_bus_err, 1);
        check("timeout wb_en", wb_en, 0);
        check("timeout in_ready", in_ready, 1);
        tick();
        check("timeout err pulse", wb_bus_err, 0);

        // Ack on the terminal-count cycle wins
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0204, 32'h5566_7788, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        check("lateack req cycle16", memBus.mem_req, 1);
        memBus.mem_ack = 1'b1;
        tick();
        memBus.mem_ack = 1'b0;
        check("lateack wb_valid", wb_valid, 1);
        check("lateack wb_bus_err", wb_bus_err, 0);
        check("lateack mem_req", memBus.mem_req, 0);

        // Ack while idle is ignored
        tick();
        memBus.mem_ack = 1'b1;
        tick();
        memBus.mem_ack = 1'b0;
        check("idle ack wb_valid", wb_valid, 0);
        check("idle ack mem_req", memBus.mem_req, 0);

        // Reset while BUSY, then a stray ack
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 5'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        check("rstbusy req before", memBus.mem_req, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstbusy mem_req", memBus.mem_req, 0);
        check("rstbusy in_ready", in_ready, 1);
        memBus.mem_rdata = 32'h1357_9BDF;
        memBus.mem_ack   = 1'b1;
        tick();
        memBus.mem_ack   = 1'b0;
        check("rstbusy wb_valid", wb_valid, 0);
        check("rstbusy mem_req after ack", memBus.mem_req, 0);
        check("rstbusy in_ready after ack", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
